// File: rtl/sisc_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : sisc_prog_loader
//  Description : Synthesizable program loader that sits in front of the SISC
//                processor. It receives a framed byte stream, assembles
//                32-bit words (MSB byte first) and writes them to the
//                instruction/data memory starting at address 0. The CPU is
//                held in reset until the image is loaded (and, optionally,
//                its checksum verified).
//
//                Frame: count[15:8], count[7:0], N x 4 payload bytes,
//                       [checksum byte = XOR of all payload bytes]
//
//  Build option: LOADER_CSUM_EN
//                  defined   - trailing checksum byte expected and checked
//                  undefined - no checksum byte; DONE follows the last write
//
//  Ports       : clk        system clock, rising edge
//                rst_n      asynchronous active-low reset
//                in_valid   stream byte valid
//                in_ready   loader can accept a byte (combinational)
//                in_data    stream byte
//                start      one-cycle pulse, re-arms from DONE or ERR
//                mem_we     memory write strobe, one cycle per word
//                mem_addr   memory write address
//                mem_wdata  memory write data
//                cpu_reset  active-high processor reset, high until DONE
//                done       image loaded (and verified)
//                err        bad count or checksum mismatch
//
//  Revision    : 1.0 - initial release
// ============================================================================
module sisc_prog_loader #(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [7:0]          in_data,
    input  logic                start,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    output logic                cpu_reset,
    output logic                done,
    output logic                err
);

    // Number of memory words; a count equal to this fills the whole memory.
    localparam logic [31:0] c_MEMSIZE = 32'(1) << ADDRSIZE;

    typedef enum logic [2:0] {
        S_HDR_HI = 3'd0,
        S_HDR_LO = 3'd1,
        S_DATA   = 3'd2,
`ifdef LOADER_CSUM_EN
        S_CSUM   = 3'd3,
`endif
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    // Header / word bookkeeping. The word counter is one bit wider than the
    // address so that a full-memory frame (count == MEMSIZE) is representable.
    logic [7:0]          r_count_hi;
    logic [ADDRSIZE:0]   r_count;
    logic [ADDRSIZE:0]   r_word_idx;
    logic [ADDRSIZE:0]   w_word_idx_inc;
    logic [1:0]          r_byte_cnt;

    // Only the first three bytes of a word need storing; the fourth comes
    // straight from in_data when the word is written.
    logic [WIDTH-9:0]    r_asm;
    logic [7:0]          r_csum;

    logic                r_mem_we;
    logic [ADDRSIZE-1:0] r_mem_addr;
    logic [WIDTH-1:0]    r_mem_wdata;

    logic                w_xfer;
    logic                w_rearm;
    logic [15:0]         w_count;
    logic                w_count_bad;
    logic                w_word_end;
    logic                w_last_word;

`ifndef LOADER_CSUM_EN
    // Set while the final word's write strobe is on the bus; the loader
    // moves to DONE once that write has been issued and accepts no further
    // bytes in the meantime.
    logic                r_last;
`endif

    assign w_count        = {r_count_hi, in_data};
    assign w_count_bad    = (w_count == 16'd0) || ({16'd0, w_count} > c_MEMSIZE);
    assign w_word_end     = (r_byte_cnt == 2'd3);
    assign w_word_idx_inc = r_word_idx + {{ADDRSIZE{1'b0}}, 1'b1};
    assign w_last_word    = (w_word_idx_inc == r_count);

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR_HI;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        cpu_reset    = 1'b1;
        w_xfer       = 1'b0;
        w_rearm      = 1'b0;

        unique case (r_state)
            S_HDR_HI: begin
                in_ready = 1'b1;
                w_xfer   = in_valid;
                if (w_xfer) begin
                    w_state_next = S_HDR_LO;
                end
            end

            S_HDR_LO: begin
                in_ready = 1'b1;
                w_xfer   = in_valid;
                if (w_xfer) begin
                    w_state_next = w_count_bad ? S_ERR : S_DATA;
                end
            end

            S_DATA: begin
`ifdef LOADER_CSUM_EN
                in_ready = 1'b1;
                w_xfer   = in_valid;
                if (w_xfer && w_word_end && w_last_word) begin
                    w_state_next = S_CSUM;
                end
`else
                in_ready = !r_last;
                w_xfer   = in_valid && !r_last;
                if (r_last) begin
                    w_state_next = S_DONE;
                end
`endif
            end

`ifdef LOADER_CSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                w_xfer   = in_valid;
                if (w_xfer) begin
                    w_state_next = (in_data == r_csum) ? S_DONE : S_ERR;
                end
            end
`endif

            S_DONE: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) begin
                    w_rearm      = 1'b1;
                    w_state_next = S_HDR_HI;
                end
            end

            S_ERR: begin
                err = 1'b1;
                if (start) begin
                    w_rearm      = 1'b1;
                    w_state_next = S_HDR_HI;
                end
            end

            default: begin
                w_state_next = S_HDR_HI;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: header latch, word assembly, checksum and write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count_hi  <= 8'd0;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_byte_cnt  <= 2'd0;
            r_asm       <= '0;
            r_csum      <= 8'd0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifndef LOADER_CSUM_EN
            r_last      <= 1'b0;
`endif
        end else begin
            // The write strobe is a single-cycle pulse by default.
            r_mem_we <= 1'b0;
`ifndef LOADER_CSUM_EN
            if (r_last) begin
                r_last <= 1'b0;
            end
`endif
            if (w_rearm) begin
                r_word_idx <= '0;
                r_csum     <= 8'd0;
                r_byte_cnt <= 2'd0;
            end else if (w_xfer) begin
                case (r_state)
                    S_HDR_HI: begin
                        r_count_hi <= in_data;
                    end

                    S_HDR_LO: begin
                        // Only meaningful when the count is legal, in which
                        // case it fits in ADDRSIZE+1 bits.
                        r_count <= w_count[ADDRSIZE:0];
                    end

                    S_DATA: begin
                        r_asm      <= {r_asm[WIDTH-17:0], in_data};
                        r_csum     <= r_csum ^ in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_word_end) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_word_idx[ADDRSIZE-1:0];
                            r_mem_wdata <= {r_asm, in_data};
                            r_word_idx  <= w_word_idx_inc;
`ifndef LOADER_CSUM_EN
                            r_last      <= w_last_word;
`endif
                        end
                    end

                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sisc_prog_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sisc_prog_loader
//  Description : Self-checking bench for sisc_prog_loader. A byte-position
//                reference model predicts in_ready, the write port and the
//                done/err/cpu_reset status every cycle; directed frames and
//                randomized frames with random idle gaps drive the DUT.
//                Honours LOADER_CSUM_EN the same way as the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sisc_prog_loader;

    localparam int ADDRSIZE = 12;
    localparam int WIDTH    = 32;
    localparam int MEMSIZE  = 1 << ADDRSIZE;

    localparam int ST_LOAD = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic                in_valid = 1'b0;
    logic [7:0]          in_data  = 8'd0;
    logic                start    = 1'b0;
    logic                in_ready;
    logic                mem_we;
    logic [ADDRSIZE-1:0] mem_addr;
    logic [WIDTH-1:0]    mem_wdata;
    logic                cpu_reset;
    logic                done;
    logic                err;

    sisc_prog_loader #(
        .WIDTH    (WIDTH),
        .ADDRSIZE (ADDRSIZE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .start     (start),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bench-side memory written by the DUT's write port.
    logic [31:0]         tb_mem [0:MEMSIZE-1];
    int                  n_writes   = 0;
    logic [ADDRSIZE-1:0] last_waddr = '0;

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr] <= mem_wdata;
            n_writes         <= n_writes + 1;
            last_waddr       <= mem_addr;
        end
    end

    // ------------------------------------------------------------------
    // Reference model: tracks the position of each accepted byte within
    // the frame and derives every expected output from it.
    // ------------------------------------------------------------------
    int          m_status;
    int          m_pos;
    int          m_count;
    logic [7:0]  m_acc;
    logic [31:0] m_word;
    bit          m_ready;
    bit          m_we;
    bit          m_pend;
    logic [11:0] m_addr;
    logic [31:0] m_data;
    bit          chk_en = 1'b0;

    function automatic void model_clear();
        m_status = ST_LOAD;
        m_pos    = 0;
        m_count  = 0;
        m_acc    = 8'd0;
        m_word   = 32'd0;
        m_pend   = 1'b0;
        m_we     = 1'b0;
        m_ready  = 1'b1;
    endfunction

    function automatic void model_step();
        int k;
        m_we = 1'b0;
        if (m_pend) begin
            m_pend   = 1'b0;
            m_status = ST_DONE;
        end else if (m_status == ST_LOAD) begin
            if (in_valid && m_ready) begin
                if (m_pos == 0) begin
                    m_count = int'(in_data);
                end else if (m_pos == 1) begin
                    m_count = m_count * 256 + int'(in_data);
                    if (m_count == 0 || m_count > MEMSIZE) m_status = ST_ERR;
                end else if (m_pos < 2 + 4 * m_count) begin
                    k      = m_pos - 2;
                    m_acc  = m_acc ^ in_data;
                    m_word = {m_word[23:0], in_data};
                    if (k % 4 == 3) begin
                        m_we   = 1'b1;
                        m_addr = 12'(k / 4);
                        m_data = m_word;
`ifndef LOADER_CSUM_EN
                        if (k / 4 == m_count - 1) m_pend = 1'b1;
`endif
                    end
                end else begin
                    m_status = (in_data == m_acc) ? ST_DONE : ST_ERR;
                end
                m_pos++;
            end
        end else if (start) begin
            m_status = ST_LOAD;
            m_pos    = 0;
            m_acc    = 8'd0;
        end
        m_ready = (m_status == ST_LOAD) && !m_pend;
    endfunction

    always @(posedge clk) begin
        if (rst_n) model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("in_ready", 32'(in_ready), 32'(m_ready));
            check("mem_we", 32'(mem_we), 32'(m_we));
            if (m_we) begin
                check("mem_addr", 32'(mem_addr), 32'(m_addr));
                check("mem_wdata", mem_wdata, m_data);
            end
            check("done", 32'(done), 32'(m_status == ST_DONE));
            check("err", 32'(err), 32'(m_status == ST_ERR));
            check("cpu_reset", 32'(cpu_reset), 32'(m_status != ST_DONE));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all entered and left at posedge + 1)
    // ------------------------------------------------------------------
    logic [7:0]  fq [$];
    logic [31:0] wq [$];

    function automatic void make_frame(input int count, input bit bad_csum);
        logic [7:0]  x;
        logic [15:0] c;
        logic [31:0] w;
        logic [7:0]  b;
        x = 8'd0;
        c = count[15:0];
        fq.delete();
        fq.push_back(c[15:8]);
        fq.push_back(c[7:0]);
        foreach (wq[i]) begin
            w = wq[i];
            for (int j = 3; j >= 0; j--) begin
                b = w[8*j +: 8];
                fq.push_back(b);
                x = x ^ b;
            end
        end
`ifdef LOADER_CSUM_EN
        fq.push_back(bad_csum ? (x ^ 8'h01) : x);
`else
        if (bad_csum) x = 8'd0;
`endif
    endfunction

    task automatic send_byte(input logic [7:0] b, input int maxgap);
        int g;
        bit sent;
        g    = (maxgap > 0) ? $urandom_range(maxgap, 0) : 0;
        sent = 1'b0;
        repeat (g) begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 20 && !sent; t++) begin
            @(negedge clk);
            if (in_ready) sent = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        if (!sent) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_byte: got in_ready=0 for 20 cycles expected handshake at %0t", $time);
        end
    endtask

    task automatic send_frame(input int maxgap);
        foreach (fq[i]) send_byte(fq[i], maxgap);
    endtask

    task automatic wait_status();
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            if (done || err) ok = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_status: got no done/err expected one within 10 cycles at %0t", $time);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("rearm_done", 32'(done), 32'd0);
        check("rearm_err", 32'(err), 32'd0);
        check("rearm_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rearm_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic load_frame1();
        wq.delete();
        wq.push_back(32'h12345678);
        wq.push_back(32'h9ABCDEF0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wbase;
        int n;
        bit bad;

        // ---- Reset state ----
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // ---- Frame 1, no gaps ----
        load_frame1();
        make_frame(2, 1'b0);
        wbase = n_writes;
        send_frame(0);
`ifdef LOADER_CSUM_EN
        check("f1_done_next_cycle", 32'(done), 32'd1);
`endif
        wait_status();
        check("f1_done", 32'(done), 32'd1);
        check("f1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("f1_in_ready", 32'(in_ready), 32'd0);
        check("f1_mem0", tb_mem[0], 32'h12345678);
        check("f1_mem1", tb_mem[1], 32'h9ABCDEF0);
        check("f1_nwrites", 32'(n_writes - wbase), 32'd2);
        do_start();

`ifdef LOADER_CSUM_EN
        // ---- Frame 1 with a wrong checksum byte (0x01) ----
        make_frame(2, 1'b1);
        send_frame(0);
        wait_status();
        check("bad_csum_err", 32'(err), 32'd1);
        check("bad_csum_done", 32'(done), 32'd0);
        check("bad_csum_cpu_reset", 32'(cpu_reset), 32'd1);
        check("bad_csum_in_ready", 32'(in_ready), 32'd0);
        do_start();
`endif

        // ---- Zero count ----
        fq.delete();
        fq.push_back(8'h00);
        fq.push_back(8'h00);
        wbase = n_writes;
        send_frame(0);
        check("cnt0_err_next_cycle", 32'(err), 32'd1);
        check("cnt0_nwrites", 32'(n_writes - wbase), 32'd0);
        do_start();

        // ---- Count of MEMSIZE+1 ----
        fq.delete();
        fq.push_back(8'h10);
        fq.push_back(8'h01);
        send_frame(0);
        check("cnt4097_err", 32'(err), 32'd1);
        do_start();

        // ---- Full memory: 4096 random words ----
        wq.delete();
        for (int i = 0; i < MEMSIZE; i++) wq.push_back($urandom);
        make_frame(MEMSIZE, 1'b0);
        wbase = n_writes;
        send_frame(0);
        wait_status();
        check("full_done", 32'(done), 32'd1);
        check("full_last_addr", 32'(last_waddr), 32'h00000FFF);
        check("full_last_word", tb_mem[MEMSIZE-1], wq[MEMSIZE-1]);
        check("full_nwrites", 32'(n_writes - wbase), 32'(MEMSIZE));
        do_start();

        // ---- Frame 1 with random idle gaps ----
        load_frame1();
        make_frame(2, 1'b0);
        send_frame(5);
        wait_status();
        check("gap_done", 32'(done), 32'd1);
        check("gap_mem0", tb_mem[0], 32'h12345678);
        check("gap_mem1", tb_mem[1], 32'h9ABCDEF0);
        do_start();

        // ---- Reset in the middle of a frame, during the first write ----
        make_frame(2, 1'b0);
        for (int i = 0; i < 6; i++) send_byte(fq[i], 0);
        check("mid_mem_we_before", 32'(mem_we), 32'd1);
        wbase = n_writes;
        rst_n = 1'b0;
        model_clear();
        #1;
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_nowrite", 32'(n_writes - wbase), 32'd0);
        load_frame1();
        make_frame(2, 1'b0);
        send_frame(2);
        wait_status();
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_mem0", tb_mem[0], 32'h12345678);
        check("post_rst_mem1", tb_mem[1], 32'h9ABCDEF0);

        // ---- Re-arm and load a one-word frame ----
        do_start();
        wq.delete();
        wq.push_back(32'h0000002A);
        make_frame(1, 1'b0);
`ifdef LOADER_CSUM_EN
        check("w2a_csum_byte", 32'(fq[6]), 32'h2A);
`endif
        send_frame(0);
        wait_status();
        check("w2a_done", 32'(done), 32'd1);
        check("w2a_mem0", tb_mem[0], 32'h0000002A);

        // ---- Randomized frames ----
        for (int r = 0; r < 8; r++) begin
            do_start();
            n = $urandom_range(8, 1);
`ifdef LOADER_CSUM_EN
            bad = ($urandom_range(3, 0) == 0);
`else
            bad = 1'b0;
`endif
            wq.delete();
            for (int i = 0; i < n; i++) wq.push_back($urandom);
            make_frame(n, bad);
            wbase = n_writes;
            send_frame($urandom_range(5, 0));
            wait_status();
            check("rnd_done", 32'(done), 32'(!bad));
            check("rnd_err", 32'(err), 32'(bad));
            check("rnd_nwrites", 32'(n_writes - wbase), 32'(n));
            check("rnd_last_word", tb_mem[n-1], wq[n-1]);
        end

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
